// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared pipeline constants, widths and stage-action encoding
package pipe_pkg;

  localparam int          DATA_W      = 32;
  localparam int          TNEW_W      = 3;
  localparam int          EXC_W       = 5;
  localparam int          PERF_W      = 16;
  localparam int          EXC_NONE    = 0;
  localparam logic [31:0] NOP         = 32'h0000_0000;
  localparam logic [31:0] HANDLER_DEF = 32'h0000_4180;

  typedef enum logic [1:0] {
    ACT_ADV   = 2'd0,
    ACT_STALL = 2'd1,
    ACT_FLUSH = 2'd2,
    ACT_REQ   = 2'd3
  } act_e;

  // Resolves the concurrent control inputs into the single action taken this edge.
  function automatic act_e pick_act(input logic req, input logic flush, input logic stall);
    if (req)        return ACT_REQ;
    else if (flush) return ACT_FLUSH;
    else if (stall) return ACT_STALL;
    else            return ACT_ADV;
  endfunction

endpackage

// File: rtl/pipe_stage_reg_if.sv
// rtl/pipe_stage_reg_if.sv - control, data-in and data-out bundle of one stage boundary
interface pipe_stage_reg_if #(
  parameter int DW    = 32,
  parameter int TW    = 3,
  parameter int EW    = 5,
  parameter int CNT_W = 16
);
  logic             stall;
  logic             flush;
  logic             req;
  logic             cnt_clr;
  logic [31:0]      instr_in;
  logic [31:0]      pc_in;
  logic             bd_in;
  logic [DW-1:0]    rs_in;
  logic [DW-1:0]    rt_in;
  logic [DW-1:0]    imm_in;
  logic [EW-1:0]    exc_in;
  logic [EW-1:0]    exc_local;
  logic [TW-1:0]    tnew_in;

  logic [31:0]      instr_out;
  logic [31:0]      pc_out;
  logic             bd_out;
  logic             valid_out;
  logic [DW-1:0]    rs_out;
  logic [DW-1:0]    rt_out;
  logic [DW-1:0]    imm_out;
  logic [EW-1:0]    exc_out;
  logic [TW-1:0]    tnew_out;
  logic [CNT_W-1:0] bubble_cnt;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output stall, flush, req, cnt_clr, instr_in, pc_in, bd_in,
           rs_in, rt_in, imm_in, exc_in, exc_local, tnew_in,
    input  instr_out, pc_out, bd_out, valid_out, rs_out, rt_out, imm_out,
           exc_out, tnew_out, bubble_cnt, stall_cnt
  );

  modport slave (
    input  stall, flush, req, cnt_clr, instr_in, pc_in, bd_in,
           rs_in, rt_in, imm_in, exc_in, exc_local, tnew_in,
    output instr_out, pc_out, bd_out, valid_out, rs_out, rt_out, imm_out,
           exc_out, tnew_out, bubble_cnt, stall_cnt
  );
endinterface

// File: rtl/pipe_perf_cnt.sv
// rtl/pipe_perf_cnt.sv - saturating event counter with synchronous clear
module pipe_perf_cnt #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_en,
  input  logic             i_clr,
  output logic [CNT_W-1:0] o_cnt
);

  logic [CNT_W-1:0] r_cnt;

  // Clear beats increment; the counter parks at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                      r_cnt <= '0;
    else if (i_clr)                  r_cnt <= '0;
    else if (i_en && (r_cnt != '1))  r_cnt <= r_cnt + CNT_W'(1);
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - inter-stage pipeline register with stall/flush/redirect and perf counters
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int          DW       = DATA_W,
  parameter int          TW       = TNEW_W,
  parameter int          EW       = EXC_W,
  parameter int          CNT_W    = PERF_W,
  parameter int          TNEW_DEC = 1,
  parameter logic [31:0] HANDLER  = HANDLER_DEF
) (
  input  logic             clk,
  input  logic             reset,
  pipe_stage_reg_if.slave  bus
);

  act_e          w_act;
  logic [EW-1:0] w_exc_nxt;
  logic [TW-1:0] w_tnew_nxt;
  logic          w_bubble_en;
  logic          w_stall_en;

  logic [31:0]   r_instr;
  logic [31:0]   r_pc;
  logic          r_bd;
  logic          r_valid;
  logic [DW-1:0] r_rs;
  logic [DW-1:0] r_rt;
  logic [DW-1:0] r_imm;
  logic [EW-1:0] r_exc;
  logic [TW-1:0] r_tnew;

  assign w_act      = pick_act(bus.req, bus.flush, bus.stall);
  assign w_exc_nxt  = (bus.exc_in != EW'(EXC_NONE)) ? bus.exc_in : bus.exc_local;
  assign w_tnew_nxt = (TNEW_DEC == 0)      ? bus.tnew_in :
                      (bus.tnew_in == '0)  ? '0 : bus.tnew_in - TW'(1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_instr <= NOP;
      r_pc    <= '0;
      r_bd    <= 1'b0;
      r_valid <= 1'b0;
      r_rs    <= '0;
      r_rt    <= '0;
      r_imm   <= '0;
      r_exc   <= EW'(EXC_NONE);
      r_tnew  <= '0;
    end else begin
      case (w_act)
        ACT_REQ, ACT_FLUSH: begin
          // A flushed slot keeps PC/BD so a later exception can still report the right EPC.
          r_instr <= NOP;
          r_pc    <= (w_act == ACT_REQ) ? HANDLER : bus.pc_in;
          r_bd    <= (w_act == ACT_REQ) ? 1'b0 : bus.bd_in;
          r_valid <= 1'b0;
          r_rs    <= '0;
          r_rt    <= '0;
          r_imm   <= '0;
          r_exc   <= EW'(EXC_NONE);
          r_tnew  <= '0;
        end
        ACT_ADV: begin
          r_instr <= bus.instr_in;
          r_pc    <= bus.pc_in;
          r_bd    <= bus.bd_in;
          r_valid <= 1'b1;
          r_rs    <= bus.rs_in;
          r_rt    <= bus.rt_in;
          r_imm   <= bus.imm_in;
          r_exc   <= w_exc_nxt;
          r_tnew  <= w_tnew_nxt;
        end
        default: ;
      endcase
    end
  end

  assign w_bubble_en = (w_act == ACT_FLUSH);
  assign w_stall_en  = (w_act == ACT_STALL);

  pipe_perf_cnt #(.CNT_W(CNT_W)) u_bubble_cnt (
    .clk   (clk),
    .reset (reset),
    .i_en  (w_bubble_en),
    .i_clr (bus.cnt_clr),
    .o_cnt (bus.bubble_cnt)
  );

  pipe_perf_cnt #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .i_en  (w_stall_en),
    .i_clr (bus.cnt_clr),
    .o_cnt (bus.stall_cnt)
  );

  assign bus.instr_out = r_instr;
  assign bus.pc_out    = r_pc;
  assign bus.bd_out    = r_bd;
  assign bus.valid_out = r_valid;
  assign bus.rs_out    = r_rs;
  assign bus.rt_out    = r_rt;
  assign bus.imm_out   = r_imm;
  assign bus.exc_out   = r_exc;
  assign bus.tnew_out  = r_tnew;

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Parametrised inter-stage pipeline register for the MIPS core (D->E, E->M, M->W); one instance per stage boundary.
- Replaces the per-stage ad-hoc registers with one block supporting stall (hold), flush (bubble preserving PC/BD), exception request (redirect to handler), Tnew countdown and exception-code merge.
- Adds saturating bubble/stall performance counters per boundary.

Parameters:
- DW, 32, width of each data field (rs, rt, imm).
- TW, 3, width of Tnew.
- EW, 5, width of exception code.
- CNT_W, 16, width of performance counters.
- TNEW_DEC, 1, 1 = decrement Tnew on capture (saturating at 0); 0 = pass through unchanged.
- HANDLER, 32'h00004180, PC loaded on exception request.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- stall  in  1  hold current contents.
- flush  in  1  load bubble, keep PC/BD of incoming instruction.
- req  in  1  exception/interrupt request; load bubble with PC=HANDLER.
- cnt_clr  in  1  synchronous clear of both counters.
- instr_in  in  32  incoming instruction.
- pc_in  in  32  incoming PC.
- bd_in  in  1  incoming branch-delay flag.
- rs_in, rt_in, imm_in  in  DW each  incoming operand/immediate data.
- exc_in  in  EW  exception carried from upstream.
- exc_local  in  EW  exception detected by the upstream stage this cycle.
- tnew_in  in  TW  upstream Tnew.
- instr_out, pc_out  out  32 each  registered instruction and PC.
- bd_out, valid_out  out  1 each  registered BD flag; 0 = bubble.
- rs_out, rt_out, imm_out  out  DW each  registered data.
- exc_out  out  EW  registered exception code.
- tnew_out  out  TW  registered Tnew.
- bubble_cnt, stall_cnt  out  CNT_W each  performance counters.

Behaviour:
- Reset (reset=0, async): instr=NOP(0), pc=0, bd=0, valid=0, data=0, exc=EXC_NONE(0), tnew=0, both counters=0.
- Per rising edge, priority is req > flush > stall > advance.
- req: instr=NOP, pc=HANDLER, bd=0, valid=0, data=0, exc=NONE, tnew=0.
- flush: instr=NOP, pc=pc_in, bd=bd_in, valid=0, data=0, exc=NONE, tnew=0.
- stall: all fields hold.
- advance: all fields capture inputs and valid=1.
  - exc = (exc_in != NONE) ? exc_in : exc_local; the earlier exception wins.
  - tnew = TNEW_DEC ? (tnew_in==0 ? 0 : tnew_in-1) : tnew_in.
- Latency: one cycle input->output. No combinational path from inputs to outputs.
- bubble_cnt: +1 on cycles where flush is taken, i.e. flush=1 and req=0.
- stall_cnt: +1 on cycles where stall is taken, i.e. stall=1, flush=0, req=0.
- Counters saturate at all-ones; no wrap.
- cnt_clr=1 forces counters to 0 that edge and overrides the increment. Pipeline fields are unaffected.
- Reset asserted mid-stall or mid-flush clears everything immediately. First edge after release behaves as a normal edge.
- Simultaneous stall+flush: bubble, stall_cnt unchanged. Simultaneous req+anything: req outcome only, no counter change.

Decomposition:
- Shared package pipe_pkg: EXC_NONE, NOP, HANDLER default, and field-width constants shared with Controller/hazard unit.
- One sub-module pipe_perf_cnt (saturating counter with enable/clear, parameter CNT_W), instantiated twice.

Test Plan:
- Reset then advance with instr_in=32'h8C220004, pc_in=32'h3004, tnew_in=2 -> next cycle instr_out=8C220004, pc_out=3004, tnew_out=1, valid_out=1.
- flush=1 with pc_in=32'h3010, bd_in=1 -> instr_out=0, pc_out=3010, bd_out=1, valid_out=0, exc_out=0, bubble_cnt=1.
- req=1 together with flush=1, stall=1 -> pc_out=32'h4180, bd_out=0, valid_out=0, both counters unchanged.
- stall=1 for 3 cycles while inputs change -> outputs frozen at prior values, stall_cnt=3; tnew_in=0 on advance -> tnew_out=0; repeat with TNEW_DEC=0 and tnew_in=2 -> tnew_out=2.
- Merge: exc_in=4, exc_local=10 -> exc_out=4; exc_in=0, exc_local=12 -> exc_out=12.
- CNT_W=2 with 5 stall cycles -> stall_cnt=3 (saturated); cnt_clr with stall=1 -> 0. Drop reset between clock edges -> outputs clear immediately, without waiting for an edge.
